// File: rtl/fetch_sequencer.sv
// Instruction fetch: PC, one-deep fetch register, branch resolution, start/done program handshake.
// Latency: ROM word at prog_ctr appears on instr one edge later; a taken branch costs one bubble.
// Backpressure: none; the fetch register advances every RUN edge. Optional CYCLE_COUNT_EN adds cycle_count.
module fetch_sequencer #(
    parameter int D  = 10,
    parameter int IW = 9,
    parameter int OW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [IW-1:0] instr_rd,
    input  logic          branch,
    input  logic          how_high,
    input  logic          br_cond,
    input  logic [OW-1:0] br_off,
    input  logic [D-1:0]  far_target,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    output logic [IW-1:0] instr,
    output logic [D-1:0]  instr_pc,
    output logic          instr_valid,
`ifdef CYCLE_COUNT_EN
    output logic          done,
    output logic [15:0]   cycle_count
`else
    output logic          done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [D-1:0] PC_ZERO = '0;
    localparam logic [D-1:0] PC_ONE  = {{(D-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [D-1:0]  pc_nxt;
    logic [D-1:0]  ipc_nxt;
    logic [IW-1:0] instr_nxt;
    logic          valid_nxt;
    logic          done_nxt;

    // Decoder feedback only counts for a real instruction while running;
    // bubbles and idle/done cycles must never steer the PC.
    logic          dec_live;
    logic          halt_hit;
    logic          taken;
    logic [D-1:0]  off_ext;
    logic [D-1:0]  rel_target;
    logic [D-1:0]  br_target;
    logic [D-1:0]  pc_inc;

    assign dec_live   = (state == S_RUN) && instr_valid;
    assign halt_hit   = dec_live && halt;
    assign taken      = dec_live && branch && br_cond;
    assign off_ext    = {{(D-OW){br_off[OW-1]}}, br_off};
    assign rel_target = instr_pc + off_ext;
    assign br_target  = how_high ? far_target : rel_target;
    assign pc_inc     = prog_ctr + PC_ONE;

    // State register and fetch datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            prog_ctr    <= PC_ZERO;
            instr       <= '0;
            instr_pc    <= PC_ZERO;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            prog_ctr    <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= ipc_nxt;
            instr_valid <= valid_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state and next-datapath selection; halt has priority over a taken branch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        instr_nxt = instr;
        ipc_nxt   = instr_pc;
        valid_nxt = instr_valid;
        done_nxt  = done;
        case (state)
            S_IDLE: begin
                // The start edge only changes mode; the first fetch happens in RUN.
                pc_nxt    = PC_ZERO;
                valid_nxt = 1'b0;
                done_nxt  = 1'b0;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_hit) begin
                    // PC freezes where it is; the fall-through fetch is dropped.
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                end else begin
                    instr_nxt = instr_rd;
                    ipc_nxt   = prog_ctr;
                    if (taken) begin
                        // The word being fetched is the fall-through: load it but squash it.
                        pc_nxt    = br_target;
                        valid_nxt = 1'b0;
                    end else begin
                        pc_nxt    = pc_inc;
                        valid_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                valid_nxt = 1'b0;
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = PC_ZERO;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = PC_ZERO;
                valid_nxt = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cnt_nxt;
    logic        run_entry;

    assign run_entry = start && ((state == S_IDLE) || (state == S_DONE));

    // Run-length counter: cleared on entry to RUN, saturating while running, frozen otherwise.
    always_comb begin
        cnt_nxt = cycle_count;
        if (run_entry) begin
            cnt_nxt = 16'd0;
        end else if ((state == S_RUN) && (cycle_count != 16'hFFFF)) begin
            cnt_nxt = cycle_count + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= 16'd0;
        end else begin
            cycle_count <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: bench-side ROM, toy decoder and a word-level fetch model checked every cycle.
// Instruction encoding used here: [8:7] op (0 plain, 1 relative branch, 2 far branch, 3 halt), [6] cond, [5:0] offset/LUT index.
// Directed program exercises sequential fetch, both branch kinds, squashed words, PC wrap, halt, restart and reset.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] instr_rd;
    logic       branch;
    logic       how_high;
    logic       br_cond;
    logic [5:0] br_off;
    logic [9:0] far_target;
    logic       halt;
    logic [9:0] prog_ctr;
    logic [8:0] instr;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       done;
`ifdef CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    logic [8:0] rom [1024];
    logic [9:0] far_lut [64];

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    fetch_sequencer #(.D(10), .IW(9), .OW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_rd   (instr_rd),
        .branch     (branch),
        .how_high   (how_high),
        .br_cond    (br_cond),
        .br_off     (br_off),
        .far_target (far_target),
        .halt       (halt),
        .prog_ctr   (prog_ctr),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
`ifdef CYCLE_COUNT_EN
        .done       (done),
        .cycle_count(cycle_count)
`else
        .done       (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM and toy decoder driven from the fetch register.
    assign instr_rd   = rom[prog_ctr];
    assign branch     = (instr[8:7] != 2'b00);
    assign how_high   = (instr[8:7] == 2'b10);
    assign br_cond    = instr[6];
    assign br_off     = instr[5:0];
    assign far_target = far_lut[instr[5:0]];
    assign halt       = (instr[8:7] == 2'b11);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: what the fetch stage must present, derived from ROM contents.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int         m_mode, m_pc, m_ipc, m_cnt;
    logic [8:0] m_instr;
    bit         m_valid, m_done;
    int         m_op, m_soff, m_nxt;
    bit         m_go;

    // Model update on every clock edge or reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_ipc = 0; m_instr = '0;
            m_valid = 0; m_done = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin m_mode = M_RUN; m_cnt = 0; end
                M_DONE: if (start) begin m_mode = M_RUN; m_pc = 0; m_done = 0; m_cnt = 0; end
                default: begin
                    if (m_cnt < 65535) m_cnt++;
                    m_op = int'(m_instr[8:7]);
                    if (m_valid && m_op == 3) begin
                        m_mode = M_DONE; m_done = 1; m_valid = 0;
                    end else begin
                        m_nxt = (m_pc + 1) % 1024;
                        m_go  = m_valid && (m_op != 0) && m_instr[6];
                        if (m_go) begin
                            m_soff = m_instr[5] ? int'(m_instr[5:0]) - 64 : int'(m_instr[5:0]);
                            m_nxt  = (m_op == 2) ? int'(far_lut[m_instr[5:0]])
                                                 : (m_ipc + m_soff + 1024) % 1024;
                        end
                        m_instr = rom[m_pc];
                        m_ipc   = m_pc;
                        m_valid = !m_go;
                        m_pc    = m_nxt;
                    end
                end
            endcase
        end
    end

    // Compare DUT against model one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("m_prog_ctr", 32'(prog_ctr), 32'(m_pc));
            chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
            chk("m_done", 32'(done), 32'(m_done));
            if (m_valid) begin
                chk("m_instr_pc", 32'(instr_pc), 32'(m_ipc));
                chk("m_instr", 32'(instr), 32'(m_instr));
            end
`ifdef CYCLE_COUNT_EN
            chk("m_cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ipc(input int t, input string name);
        int n = 0;
        while (!(instr_valid && instr_pc == 10'(t)) && n < 200) begin
            tick();
            n++;
        end
        chk(name, {21'd0, instr_valid, instr_pc}, {21'd0, 1'b1, 10'(t)});
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = {2'b00, 7'(a * 37 + 5)};
        for (int i = 0; i < 64; i++) far_lut[i] = 10'(i * 16);
        far_lut[0]      = 10'h3F0;
        rom[5]          = {2'b01, 1'b1, 6'b111101};  // relative -3, taken
        rom[7]          = {2'b10, 1'b1, 6'd0};       // far to 3F0
        rom[8]          = {2'b11, 1'b1, 6'd1};       // halt in a squashed slot
        rom[10'h3F0]    = {2'b01, 1'b1, 6'd2};       // back-to-back: branch +2
        rom[10'h3F1]    = {2'b01, 1'b1, 6'b111111};  // squashed branch
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1;
        chk("rst_prog_ctr", 32'(prog_ctr), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // Start: first RUN edge leaves PC 0 and no valid word.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_pc", 32'(prog_ctr), 32'h0);
        chk("start_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("seq1_pc", 32'(prog_ctr), 32'h1);
        chk("seq1_ipc", 32'(instr_pc), 32'h0);
        chk("seq1_valid", 32'(instr_valid), 32'h1);
        chk("seq1_instr", 32'(instr), 32'h005);
        tick();
        chk("seq2_pc", 32'(prog_ctr), 32'h2);
        chk("seq2_ipc", 32'(instr_pc), 32'h1);
        tick();
        chk("seq3_pc", 32'(prog_ctr), 32'h3);
        chk("seq3_ipc", 32'(instr_pc), 32'h2);

        // Relative branch at 5, offset -3, taken.
        wait_ipc(5, "wait_rel_taken");
        chk("rel_fall_pc", 32'(prog_ctr), 32'h6);
        tick();
        chk("rel_bubble", 32'(instr_valid), 32'h0);
        chk("rel_target_pc", 32'(prog_ctr), 32'h2);
        rom[5] = {2'b01, 1'b0, 6'b111101};
        tick();
        chk("rel_tgt_valid", 32'(instr_valid), 32'h1);
        chk("rel_tgt_ipc", 32'(instr_pc), 32'h2);

        // Same branch with cond 0: straight through, no bubble.
        wait_ipc(5, "wait_rel_nt");
        tick();
        chk("nt_valid", 32'(instr_valid), 32'h1);
        chk("nt_ipc", 32'(instr_pc), 32'h6);

        // Far branch at 7 to 3F0; squashed halt at 8 must be ignored.
        wait_ipc(7, "wait_far");
        tick();
        chk("far_bubble", 32'(instr_valid), 32'h0);
        chk("far_pc", 32'(prog_ctr), 32'h3F0);
        rom[4] = {2'b11, 1'b1, 6'd3};  // halt with a taken branch to 7 alongside
        tick();
        chk("far_tgt_ipc", 32'(instr_pc), 32'h3F0);
        chk("far_tgt_valid", 32'(instr_valid), 32'h1);
        tick();
        chk("b2b_bubble", 32'(instr_valid), 32'h0);
        chk("b2b_pc", 32'(prog_ctr), 32'h3F2);
        tick();
        chk("b2b_ipc", 32'(instr_pc), 32'h3F2);

        // Wrap and halt at 4.
        wait_ipc(10'h3FF, "wait_wrap");
        chk("wrap_pc", 32'(prog_ctr), 32'h0);
        begin
            int n = 0;
            while (!done && n < 50) begin tick(); n++; end
        end
        chk("halt_done", 32'(done), 32'h1);
        chk("halt_valid", 32'(instr_valid), 32'h0);
        chk("halt_pc", 32'(prog_ctr), 32'h5);
        tick();
        tick();
        chk("done_hold", 32'(done), 32'h1);
        chk("done_pc_hold", 32'(prog_ctr), 32'h5);

        // Restart from DONE with a plain program up to address 9.
        rom[4] = {2'b00, 7'd3};
        rom[7] = {2'b00, 7'd11};
        rom[8] = {2'b00, 7'd13};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", 32'(done), 32'h0);
        chk("restart_pc", 32'(prog_ctr), 32'h0);
        chk("restart_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("restart_ipc", 32'(instr_pc), 32'h0);
        chk("restart_vld1", 32'(instr_valid), 32'h1);
        begin
            int n = 0;
            while (prog_ctr != 10'd9 && n < 50) begin tick(); n++; end
        end
        chk("pre_reset_pc", 32'(prog_ctr), 32'h9);

        // Asynchronous reset mid-run, checked before any clock edge.
        reset = 1'b1;
        #1;
        chk("arst_pc", 32'(prog_ctr), 32'h0);
        chk("arst_instr", 32'(instr), 32'h0);
        chk("arst_ipc", 32'(instr_pc), 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("idle_pc", 32'(prog_ctr), 32'h0);
        chk("idle_valid", 32'(instr_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
